fib_seq_gen: RTL and testbench

Parametrised Fibonacci-class sequence generator and successor to the free-running Fibonacci counter. Adds loadable seeds (Fibonacci, Lucas, or any two-term recurrence), a valid/ready output handshake with backpressure, enable, overflow detection with wrap or stop modes, and a term index. Single clock edge throughout. Feeds counter and datapath exercises on the FPGA board, or any consumer needing a paced recurrence stream.

---
 rtl/fib_seq_gen_if.sv | 44 ++++
 rtl/fib_seq_gen.sv | 118 +++++++++++
 tb/tb_fib_seq_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_seq_gen_if.sv
// ---------------------------------------------------------------------------
// fib_seq_gen_if
//   Control and output-stream bundle for the Fibonacci-class sequence
//   generator.
//
//   Signals (directions seen from the generator, modport master):
//     en         in   advance enable
//     load       in   synchronous seed load
//     seed0      in   W   first term loaded by load
//     seed1      in   W   second term loaded by load
//     out_ready  in   consumer accepts the current term
//     out        out  W   current term
//     out_valid  out  current term valid
//     index      out  IW  index of the current term, 0 = first term
//     ovf        out  sticky overflow flag
//     done       out  generator halted
//
//   The slave modport is the consumer/controller view of the same bundle.
// ---------------------------------------------------------------------------
interface fib_seq_gen_if #(
    parameter int W  = 16,
    parameter int IW = 8
);
    logic          en;
    logic          load;
    logic [W-1:0]  seed0;
    logic [W-1:0]  seed1;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          out_valid;
    logic [IW-1:0] index;
    logic          ovf;
    logic          done;

    modport master (
        input  en, load, seed0, seed1, out_ready,
        output out, out_valid, index, ovf, done
    );

    modport slave (
        output en, load, seed0, seed1, out_ready,
        input  out, out_valid, index, ovf, done
    );
endinterface

// File: rtl/fib_seq_gen.sv
// ---------------------------------------------------------------------------
// fib_seq_gen
//   Two-term recurrence generator (Fibonacci, Lucas, or any seeded pair)
//   with a valid/ready output stream, enable, sticky overflow detection with
//   wrap or stop behaviour, and a saturating term index.
//
//   Parameters:
//     W         data width of every term
//     IW        width of the term index counter
//     SAT_MODE  0 = wrap on overflow and keep running,
//               1 = stop after the last representable term
//
//   Ports:
//     clk   in   clock, all logic on the rising edge
//     rst   in   synchronous active-high reset, highest priority
//     bus   fib_seq_gen_if.master  control inputs and output stream
//
//   Only out_valid is combinational; every other output is a register.
// ---------------------------------------------------------------------------
module fib_seq_gen #(
    parameter int W        = 16,
    parameter int IW       = 8,
    parameter int SAT_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    fib_seq_gen_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,   // presenting terms, recurrence advancing
        ST_LAST = 2'd1,   // presenting the final term before a stop
        ST_HALT = 2'd2    // stopped until rst or load
    } state_t;

    logic [W-1:0]  r_a;       // current term, drives out
    logic [W-1:0]  r_b;       // next term
    logic [IW-1:0] r_index;
    logic          r_ovf;
    logic          r_done;
    state_t        r_state;

    logic [W:0]    w_sum;
    logic          w_idx_max;
    logic          w_out_valid;
    logic          w_xfer;

    // One extra bit so the carry out of the addition is the overflow flag.
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_idx_max = (r_index == {IW{1'b1}});

    // NOTE: out_valid is deliberately combinational so that dropping en or
    // raising load withdraws the term in the same cycle; a load cycle can
    // therefore never also be a transfer.
    assign w_out_valid = (r_state != ST_HALT) && bus.en && !bus.load;
    assign w_xfer      = w_out_valid && bus.out_ready;

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register samples the pre-edge values of its
    // neighbours (a <= b and b <= a + b read the old a and b).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= W'(1);
            r_index <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (bus.load) begin
            r_a     <= bus.seed0;
            r_b     <= bus.seed1;
            r_index <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (w_xfer) begin
            case (r_state)
                ST_RUN: begin
                    if (w_idx_max) begin
                        // Index would wrap: stop with the final term still
                        // on out. This wins over any overflow handling.
                        r_state <= ST_HALT;
                        r_done  <= 1'b1;
                    end else begin
                        r_a     <= r_b;
                        r_index <= r_index + IW'(1);
                        if (!w_sum[W]) begin
                            r_b <= w_sum[W-1:0];
                        end else if (SAT_MODE == 0) begin
                            r_b   <= w_sum[W-1:0];
                            r_ovf <= 1'b1;
                        end else begin
                            // b is not representable; b (now on its way to
                            // a) is the last valid term, so present it once
                            // more via LAST and then stop.
                            r_ovf   <= 1'b1;
                            r_state <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    r_state <= ST_HALT;
                    r_done  <= 1'b1;
                end
                default: begin
                    // HALT never transfers because out_valid is low.
                end
            endcase
        end
    end

    assign bus.out       = r_a;
    assign bus.out_valid = w_out_valid;
    assign bus.index     = r_index;
    assign bus.ovf       = r_ovf;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_fib_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_fib_seq_gen
//   Drives four generator configurations in lockstep from shared stimulus:
//     dut0  W=16 IW=8 wrap
//     dut1  W=8  IW=8 wrap
//     dut2  W=8  IW=8 stop
//     dut3  W=16 IW=3 wrap
//   The reference model precomputes, for each configuration, the list of
//   terms the generator will emit from a given seed pair, the sticky
//   overflow flag seen while each term is presented, and how many terms are
//   emitted before the generator stops. The model then only tracks a
//   position in that list.
// ---------------------------------------------------------------------------
module tb_fib_seq_gen;

    localparam int WD   [4] = '{16, 8, 8, 16};
    localparam int IWD  [4] = '{8, 8, 8, 3};
    localparam int SATD [4] = '{0, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_r;
    logic        en_r;
    logic        load_r;
    logic        rdy_r;
    logic [15:0] seed0_r;
    logic [15:0] seed1_r;

    initial forever #5 clk = ~clk;

    fib_seq_gen_if #(.W(16), .IW(8)) if0 ();
    fib_seq_gen_if #(.W(8),  .IW(8)) if1 ();
    fib_seq_gen_if #(.W(8),  .IW(8)) if2 ();
    fib_seq_gen_if #(.W(16), .IW(3)) if3 ();

    assign if0.en = en_r;  assign if0.load = load_r;  assign if0.out_ready = rdy_r;
    assign if1.en = en_r;  assign if1.load = load_r;  assign if1.out_ready = rdy_r;
    assign if2.en = en_r;  assign if2.load = load_r;  assign if2.out_ready = rdy_r;
    assign if3.en = en_r;  assign if3.load = load_r;  assign if3.out_ready = rdy_r;
    assign if0.seed0 = seed0_r;       assign if0.seed1 = seed1_r;
    assign if1.seed0 = seed0_r[7:0];  assign if1.seed1 = seed1_r[7:0];
    assign if2.seed0 = seed0_r[7:0];  assign if2.seed1 = seed1_r[7:0];
    assign if3.seed0 = seed0_r;       assign if3.seed1 = seed1_r;

    fib_seq_gen #(.W(16), .IW(8), .SAT_MODE(0)) dut0 (.clk(clk), .rst(rst_r), .bus(if0.master));
    fib_seq_gen #(.W(8),  .IW(8), .SAT_MODE(0)) dut1 (.clk(clk), .rst(rst_r), .bus(if1.master));
    fib_seq_gen #(.W(8),  .IW(8), .SAT_MODE(1)) dut2 (.clk(clk), .rst(rst_r), .bus(if2.master));
    fib_seq_gen #(.W(16), .IW(3), .SAT_MODE(0)) dut3 (.clk(clk), .rst(rst_r), .bus(if3.master));

    // Observed outputs packed as {out_valid, done, ovf, index[7:0], out[15:0]}.
    logic [26:0] obs [4];
    assign obs[0] = {if0.out_valid, if0.done, if0.ovf, if0.index, if0.out};
    assign obs[1] = {if1.out_valid, if1.done, if1.ovf, if1.index, 8'h00, if1.out};
    assign obs[2] = {if2.out_valid, if2.done, if2.ovf, if2.index, 8'h00, if2.out};
    assign obs[3] = {if3.out_valid, if3.done, if3.ovf, 5'b00000, if3.index, if3.out};

    // Reference model state.
    longint term   [4][258];
    bit     ovfl   [4][258];
    int     nterm  [4];
    int     kk     [4];
    bit     halted [4];

    int n_vec = 0;
    int n_err = 0;

    // Emitted term list for one configuration from a seed pair.
    function automatic void build(int d, longint s0, longint s1);
        longint mask = (longint'(1) << WD[d]) - 1;
        longint sum;
        int     n    = 1 << IWD[d];
        term[d][0] = s0 & mask;
        term[d][1] = s1 & mask;
        ovfl[d][0] = 1'b0;
        nterm[d]   = n;
        for (int j = 0; j < n - 1; j++) begin
            sum            = term[d][j] + term[d][j+1];
            term[d][j+2]   = sum & mask;
            ovfl[d][j+1]   = ovfl[d][j] | (sum > mask);
            if (SATD[d] != 0 && sum > mask) begin
                nterm[d] = j + 2;
                break;
            end
        end
        kk[d]     = 0;
        halted[d] = 1'b0;
    endfunction

    function automatic logic [26:0] exp_vec(int d);
        logic v = !halted[d] && en_r && !load_r;
        return {v, halted[d], ovfl[d][kk[d]], 8'(kk[d]), 16'(term[d][kk[d]])};
    endfunction

    // Called at a falling edge: set inputs, let out_valid settle.
    task automatic apply(input logic r, input logic e, input logic l, input logic rd,
                         input logic [15:0] s0, input logic [15:0] s1);
        rst_r   = r;
        en_r    = e;
        load_r  = l;
        rdy_r   = rd;
        seed0_r = s0;
        seed1_r = s1;
        #1;
    endtask

    // Advance the model for the coming rising edge, then move to the next
    // falling edge.
    task automatic tick();
        for (int d = 0; d < 4; d++) begin
            if (rst_r) begin
                build(d, 0, 1);
            end else if (load_r) begin
                build(d, longint'(seed0_r), longint'(seed1_r));
            end else if (en_r && rdy_r && !halted[d]) begin
                if (kk[d] == nterm[d] - 1) halted[d] = 1'b1;
                else                       kk[d]     = kk[d] + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL reset dut%0d t=%0t: got %h want %h (valid,done,ovf,index,out)", d, $time, obs[d], exp_vec(d));
                end
            end
            tick();
        end
        n_vec++;
        if (if0.out !== 16'd0 || if0.index !== 8'd0 || if0.ovf !== 1'b0 || if0.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got out=%0d index=%0d ovf=%b done=%b want 0 0 0 0", if0.out, if0.index, if0.ovf, if0.done);
        end
    endtask

    task automatic test_fib_basic();
        logic [15:0] fib_ref [8] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL fib_basic dut%0d t=%0t: got %h want %h", d, $time, obs[d], exp_vec(d));
                end
            end
            n_vec++;
            if (if0.out !== fib_ref[i] || if0.index !== 8'(i) || if0.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL fib_term%0d: got out=%0d index=%0d valid=%b want %0d %0d 1", i, if0.out, if0.index, if0.out_valid, fib_ref[i], i);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        // Pattern: reset, accept 0,1,1,2,3, stall with ready low, stall with
        // en low, then resume.
        logic pat_rst [15] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        logic pat_en  [15] = '{1,1,1,1,1,1,1,1,1,0,0,0,1,1,1};
        logic pat_rdy [15] = '{1,1,1,1,1,1,0,0,0,1,1,1,1,1,1};
        for (int i = 0; i < 15; i++) begin
            apply(pat_rst[i], pat_en[i], 1'b0, pat_rdy[i], 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL backpressure dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            if (i >= 6 && i <= 11) begin
                n_vec++;
                if (if0.out !== 16'd5 || if0.index !== 8'd5 || if0.out_valid !== pat_en[i]) begin
                    n_err++;
                    $display("FAIL stall_hold step %0d: got out=%0d index=%0d valid=%b want 5 5 %b", i, if0.out, if0.index, if0.out_valid, pat_en[i]);
                end
            end
            tick();
        end
        n_vec++;
        if (if0.out !== 16'd21) begin
            n_err++;
            $display("FAIL resume: got out=%0d want 21", if0.out);
        end
    endtask

    task automatic test_overflow();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        tick();
        for (int i = 0; i < 24; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL overflow dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            if (i == 13) begin
                n_vec++;
                if (if1.out !== 8'd233 || if1.ovf !== 1'b1 || if2.out !== 8'd233 || if2.ovf !== 1'b1 || if2.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_rise: got wrap out=%0d ovf=%b stop out=%0d ovf=%b valid=%b want 233 1 233 1 1",
                             if1.out, if1.ovf, if2.out, if2.ovf, if2.out_valid);
                end
            end
            tick();
        end
        n_vec++;
        if (if2.done !== 1'b1 || if2.out !== 8'd233 || if2.out_valid !== 1'b0 || if1.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL sat_stop: got done=%b out=%0d valid=%b wrap_ovf=%b want 1 233 0 1", if2.done, if2.out, if2.out_valid, if1.ovf);
        end
    endtask

    task automatic test_load();
        logic [15:0] load_ref [6] = '{16'd2, 16'd1, 16'd3, 16'd4, 16'd7, 16'd11};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            tick();
        end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 16'd1);
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (obs[d] !== exp_vec(d)) begin
                n_err++;
                $display("FAIL load_cycle dut%0d: got %h want %h", d, obs[d], exp_vec(d));
            end
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL load_run dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            if (i < 6) begin
                n_vec++;
                if (if0.out !== load_ref[i] || if0.index !== 8'(i) || if0.ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_term%0d: got out=%0d index=%0d ovf=%b want %0d %0d 0", i, if0.out, if0.index, if0.ovf, load_ref[i], i);
                end
            end
            tick();
        end
        n_vec++;
        if (if3.done !== 1'b1 || if3.out !== 16'd29 || if3.index !== 3'd7) begin
            n_err++;
            $display("FAIL index_limit_iw3: got done=%b out=%0d index=%0d want 1 29 7", if3.done, if3.out, if3.index);
        end
    endtask

    task automatic test_index_limit();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        tick();
        for (int i = 0; i < 262; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            if (i % 16 == 0 || i >= 254) begin
                for (int d = 0; d < 4; d++) begin
                    n_vec++;
                    if (obs[d] !== exp_vec(d)) begin
                        n_err++;
                        $display("FAIL index_limit dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                    end
                end
            end
            tick();
        end
        n_vec++;
        if (if0.done !== 1'b1 || if0.index !== 8'd255 || if1.done !== 1'b1) begin
            n_err++;
            $display("FAIL index_limit_iw8: got done=%b index=%0d w8_done=%b want 1 255 1", if0.done, if0.index, if1.done);
        end
    endtask

    task automatic test_rst_priority();
        logic [15:0] rst_ref [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
        apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 16'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL rst_priority dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            n_vec++;
            if (if0.out !== rst_ref[i] || if0.done !== 1'b0 || if0.ovf !== 1'b0) begin
                n_err++;
                $display("FAIL rst_wins step %0d: got out=%0d done=%b ovf=%b want %0d 0 0", i, if0.out, if0.done, if0.ovf, rst_ref[i]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(99) == 0), ($urandom_range(9) != 0), ($urandom_range(39) == 0),
                  ($urandom_range(3) != 0), 16'($urandom), 16'($urandom));
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (obs[d] !== exp_vec(d)) begin
                    n_err++;
                    $display("FAIL random dut%0d step %0d: got %h want %h", d, i, obs[d], exp_vec(d));
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_r   = 1'b1;
        en_r    = 1'b0;
        load_r  = 1'b0;
        rdy_r   = 1'b0;
        seed0_r = 16'h0000;
        seed1_r = 16'h0000;
        for (int d = 0; d < 4; d++) build(d, 0, 1);
        @(negedge clk);

        test_reset();
        test_fib_basic();
        test_backpressure();
        test_overflow();
        test_load();
        test_index_limit();
        test_rst_priority();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
